// File: rtl/hazard_pkg.sv
// Shared definitions for the MIPS hazard/bypass controller: opcodes, enums,
// mux select encodings and the scoreboard entry layout.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  typedef enum logic [1:0] {SRC_ALU, SRC_DM, SRC_PC8} src_e;

  typedef enum logic [3:0] {
    C_NONE, C_ALU, C_LOAD, C_STORE, C_BR, C_JR, C_JAL, C_MD, C_MDMOV
  } iclass_e;

  localparam logic [1:0] TUSE_NEVER = 2'd3;

  localparam logic [2:0] DSEL_RF   = 3'd0;
  localparam logic [2:0] DSEL_PC8E = 3'd1;
  localparam logic [2:0] DSEL_ALUM = 3'd2;
  localparam logic [2:0] DSEL_PC8M = 3'd3;
  localparam logic [2:0] DSEL_WD   = 3'd4;

  localparam logic [2:0] ESEL_REG  = 3'd0;
  localparam logic [2:0] ESEL_ALUM = 3'd1;
  localparam logic [2:0] ESEL_PC8M = 3'd2;
  localparam logic [2:0] ESEL_WD   = 3'd3;

  localparam logic [2:0] MSEL_REG  = 3'd0;
  localparam logic [2:0] MSEL_WD   = 3'd1;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] tnew;
    src_e       src;
    logic [4:0] rs;
    logic [4:0] rt;
  } sb_entry_t;

  // A write to $0 is architecturally discarded, so it never matches.
  function automatic logic sbHit(input sb_entry_t e, input logic [4:0] r);
    return e.valid && (e.dst == r) && (r != 5'd0);
  endfunction

  function automatic sb_entry_t sbAge(input sb_entry_t e);
    sb_entry_t a;
    a = e;
    if (a.tnew != 2'd0) a.tnew = a.tnew - 2'd1;
    return a;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational decode of a D-stage instruction into register usage,
// Tuse/Tnew timing, result source and instruction class.
module instr_decode
  import hazard_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  dst_o,
  output logic [1:0]  tuse_rs_o,
  output logic [1:0]  tuse_rt_o,
  output logic [1:0]  tnew_o,
  output src_e        src_o,
  output iclass_e     cls_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rsField;
  logic [4:0] rtField;
  logic [4:0] rdField;
  logic       unusedShamt;

  assign opcode      = ir_i[31:26];
  assign rsField     = ir_i[25:21];
  assign rtField     = ir_i[20:16];
  assign rdField     = ir_i[15:11];
  assign funct       = ir_i[5:0];
  assign unusedShamt = ^ir_i[10:6];

  always_comb begin
    dst_o     = 5'd0;
    tuse_rs_o = TUSE_NEVER;
    tuse_rt_o = TUSE_NEVER;
    tnew_o    = 2'd0;
    src_o     = SRC_ALU;
    cls_o     = C_NONE;
    unique case (opcode)
      OP_RTYPE: begin
        dst_o = rdField;
        case (funct)
          FN_ADDU, FN_SUBU: begin
            tuse_rs_o = 2'd1;
            tuse_rt_o = 2'd1;
            tnew_o    = 2'd1;
            cls_o     = C_ALU;
          end
          FN_JR: begin
            tuse_rs_o = 2'd0;
            cls_o     = C_JR;
          end
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
            tuse_rs_o = 2'd1;
            tuse_rt_o = 2'd1;
            cls_o     = C_MD;
          end
          FN_MFHI, FN_MFLO: begin
            tnew_o = 2'd1;
            cls_o  = C_MDMOV;
          end
          FN_MTHI, FN_MTLO: begin
            tuse_rs_o = 2'd1;
            cls_o     = C_MDMOV;
          end
          default: ;
        endcase
      end
      OP_ORI, OP_LUI: begin
        dst_o     = rtField;
        tuse_rs_o = 2'd1;
        tnew_o    = 2'd1;
        cls_o     = C_ALU;
      end
      OP_LW: begin
        dst_o     = rtField;
        tuse_rs_o = 2'd1;
        tnew_o    = 2'd2;
        src_o     = SRC_DM;
        cls_o     = C_LOAD;
      end
      OP_SW: begin
        tuse_rs_o = 2'd1;
        tuse_rt_o = 2'd2;
        cls_o     = C_STORE;
      end
      OP_BEQ: begin
        tuse_rs_o = 2'd0;
        tuse_rt_o = 2'd0;
        cls_o     = C_BR;
      end
      OP_JAL: begin
        dst_o = 5'd31;
        src_o = SRC_PC8;
        cls_o = C_JAL;
      end
      default: ;
    endcase
  end

  // Unread source fields are zeroed so they can never trigger a forward downstream.
  assign rs_o = (tuse_rs_o == TUSE_NEVER) ? 5'd0 : rsField;
  assign rt_o = (tuse_rt_o == TUSE_NEVER) ? 5'd0 : rtField;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and bypass controller: E/M/W scoreboard, Tuse/Tnew stall logic,
// bypass mux selects and the mult/div busy counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_d,
  output logic        stall,
  output logic [2:0]  rsd_sel,
  output logic [2:0]  rtd_sel,
  output logic [2:0]  rse_sel,
  output logic [2:0]  rte_sel,
  output logic [2:0]  rtm_sel,
  output logic        md_busy
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);

  logic [4:0]  decRs, decRt, decDst;
  logic [1:0]  decTuseRs, decTuseRt, decTnew;
  src_e        decSrc;
  iclass_e     decCls;

  sb_entry_t   stageE_q, stageM_q, stageW_q;
  sb_entry_t   stageE_d, stageM_d, stageW_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic dataStall, mdStall, isMd, isDiv;
  logic unusedBits;

  instr_decode u_decode (
    .ir_i      (ir_d),
    .rs_o      (decRs),
    .rt_o      (decRt),
    .dst_o     (decDst),
    .tuse_rs_o (decTuseRs),
    .tuse_rt_o (decTuseRt),
    .tnew_o    (decTnew),
    .src_o     (decSrc),
    .cls_o     (decCls)
  );

  // Only the nearest producer matters; W results are always ready.
  function automatic logic srcStall(input logic [4:0] r, input logic [1:0] tuse,
                                    input sb_entry_t e, input sb_entry_t m);
    if (tuse == TUSE_NEVER) return 1'b0;
    if (sbHit(e, r)) return e.tnew > tuse;
    if (sbHit(m, r)) return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [2:0] dSel(input logic [4:0] r, input sb_entry_t e,
                                      input sb_entry_t m, input sb_entry_t w);
    if (sbHit(e, r)) return (e.tnew == 2'd0 && e.src == SRC_PC8) ? DSEL_PC8E : DSEL_RF;
    if (sbHit(m, r)) begin
      if (m.tnew != 2'd0) return DSEL_RF;
      if (m.src == SRC_PC8) return DSEL_PC8M;
      if (m.src == SRC_ALU) return DSEL_ALUM;
      return DSEL_RF;
    end
    if (sbHit(w, r)) return DSEL_WD;
    return DSEL_RF;
  endfunction

  function automatic logic [2:0] eSel(input logic [4:0] r, input sb_entry_t m,
                                      input sb_entry_t w);
    if (sbHit(m, r)) begin
      if (m.tnew != 2'd0) return ESEL_REG;
      if (m.src == SRC_PC8) return ESEL_PC8M;
      if (m.src == SRC_ALU) return ESEL_ALUM;
      return ESEL_REG;
    end
    if (sbHit(w, r)) return ESEL_WD;
    return ESEL_REG;
  endfunction

  assign isMd    = (decCls == C_MD);
  assign isDiv   = (ir_d[5:0] == FN_DIV) || (ir_d[5:0] == FN_DIVU);
  assign md_busy = (cnt_q != '0);

  assign dataStall = srcStall(decRs, decTuseRs, stageE_q, stageM_q) |
                     srcStall(decRt, decTuseRt, stageE_q, stageM_q);
  assign mdStall   = (isMd || decCls == C_MDMOV) && md_busy;
  assign stall     = dataStall | mdStall;

  assign rsd_sel = dSel(decRs, stageE_q, stageM_q, stageW_q);
  assign rtd_sel = dSel(decRt, stageE_q, stageM_q, stageW_q);
  assign rse_sel = eSel(stageE_q.rs, stageM_q, stageW_q);
  assign rte_sel = eSel(stageE_q.rt, stageM_q, stageW_q);
  assign rtm_sel = sbHit(stageW_q, stageM_q.rt) ? MSEL_WD : MSEL_REG;

  assign unusedBits = ^{stageM_q.rs, stageW_q.tnew, stageW_q.src, stageW_q.rs, stageW_q.rt};

  // A stalled D stage injects an all-zero bubble so it cannot match or forward.
  always_comb begin
    stageW_d = sbAge(stageM_q);
    stageM_d = sbAge(stageE_q);
    stageE_d = '0;
    if (!stall) begin
      stageE_d = '{valid: 1'b1, dst: decDst, tnew: decTnew, src: decSrc,
                   rs: decRs, rt: decRt};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (isMd && !stall) cnt_d = isDiv ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    else if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stageE_q <= '0;
      stageM_q <= '0;
      stageW_q <= '0;
      cnt_q    <= '0;
    end else begin
      stageE_q <= stageE_d;
      stageM_q <= stageM_d;
      stageW_q <= stageW_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: each step drives one D-stage
// instruction and compares stall/selects/busy against hand-derived values.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_d;
  logic        stall;
  logic [2:0]  rsd_sel, rtd_sel, rse_sel, rte_sel, rtm_sel;
  logic        md_busy;

  logic [16:0] expQ[$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .ir_d    (ir_d),
    .stall   (stall),
    .rsd_sel (rsd_sel),
    .rtd_sel (rtd_sel),
    .rse_sel (rse_sel),
    .rte_sel (rte_sel),
    .rtm_sel (rtm_sel),
    .md_busy (md_busy)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [16:0] mk(input logic st, input logic [2:0] rsd, input logic [2:0] rtd,
                                     input logic [2:0] rse, input logic [2:0] rte,
                                     input logic [2:0] rtm, input logic busy);
    return {st, rsd, rtd, rse, rte, rtm, busy};
  endfunction

  task automatic applyStimulus(input logic [31:0] ir, input logic rst, input logic [16:0] exp);
    @(posedge clk);
    #1;
    ir_d  = ir;
    reset = rst;
    expQ.push_back(exp);
  endtask

  task automatic checkOutput(input string tag);
    logic [16:0] obs;
    logic [16:0] exp;
    @(negedge clk);
    obs = {stall, rsd_sel, rtd_sel, rse_sel, rte_sel, rtm_sel, md_busy};
    exp = expQ.pop_front();
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed={st%b d%0d/%0d e%0d/%0d m%0d busy%b} expected={st%b d%0d/%0d e%0d/%0d m%0d busy%b}",
             tag, obs[16], obs[15:13], obs[12:10], obs[9:7], obs[6:4], obs[3:1], obs[0],
             exp[16], exp[15:13], exp[12:10], exp[9:7], exp[6:4], exp[3:1], exp[0]);
    end
  endtask

  task automatic step(input logic [31:0] ir, input logic rst, input logic [16:0] exp, input string tag);
    applyStimulus(ir, rst, exp);
    checkOutput(tag);
  endtask

  logic [31:0] NOP, LW8, ADDU9, ADDU3, BEQ3, JAL, JR31, ADDU10, ORI0, ADDU11, BEQ00;
  logic [31:0] ADDU7, SW7, LW12, SW12, DIV45, MFLO6, MULT45, MFHI2, LW4;

  initial begin
    NOP    = 32'd0;
    LW8    = itype(6'h23, 5'd0, 5'd8, 16'd0);
    ADDU9  = rtype(5'd8, 5'd8, 5'd9, 6'h21);
    ADDU3  = rtype(5'd1, 5'd2, 5'd3, 6'h21);
    BEQ3   = itype(6'h04, 5'd3, 5'd0, 16'd0);
    JAL    = {6'h03, 26'd0};
    JR31   = rtype(5'd31, 5'd0, 5'd0, 6'h08);
    ADDU10 = rtype(5'd31, 5'd0, 5'd10, 6'h21);
    ORI0   = itype(6'h0D, 5'd0, 5'd0, 16'd5);
    ADDU11 = rtype(5'd0, 5'd0, 5'd11, 6'h21);
    BEQ00  = itype(6'h04, 5'd0, 5'd0, 16'd0);
    ADDU7  = rtype(5'd1, 5'd2, 5'd7, 6'h21);
    SW7    = itype(6'h2B, 5'd0, 5'd7, 16'd0);
    LW12   = itype(6'h23, 5'd0, 5'd12, 16'd0);
    SW12   = itype(6'h2B, 5'd0, 5'd12, 16'd0);
    DIV45  = rtype(5'd4, 5'd5, 5'd0, 6'h1A);
    MFLO6  = rtype(5'd0, 5'd0, 5'd6, 6'h12);
    MULT45 = rtype(5'd4, 5'd5, 5'd0, 6'h18);
    MFHI2  = rtype(5'd0, 5'd0, 5'd2, 6'h10);
    LW4    = itype(6'h23, 5'd0, 5'd4, 16'd0);

    reset = 1'b1;
    ir_d  = NOP;
    repeat (2) @(posedge clk);
    $display("[TB] starting directed sequence");

    step(NOP,    1'b0, mk(0,0,0,0,0,0,0), "reset_state");

    // Load-use: one stall, then addu in E takes both operands from W.
    step(LW8,    1'b0, mk(0,0,0,0,0,0,0), "lw_issue");
    step(ADDU9,  1'b0, mk(1,0,0,0,0,0,0), "loaduse_stall");
    step(ADDU9,  1'b0, mk(0,0,0,0,0,0,0), "loaduse_release");
    step(NOP,    1'b0, mk(0,0,0,3,3,0,0), "loaduse_e_fwd_w");
    step(NOP,    1'b0, mk(0,0,0,0,0,0,0), "bubble_quiet");

    // ALU result into branch: one stall, then aluout_m bypass.
    step(ADDU3,  1'b0, mk(0,0,0,0,0,0,0), "addu3_issue");
    step(BEQ3,   1'b0, mk(1,0,0,0,0,0,0), "beq_stall");
    step(BEQ3,   1'b0, mk(0,2,0,0,0,0,0), "beq_fwd_aluout_m");

    // jal/jr: PC+8 bypasses from E, M and W.
    step(JAL,    1'b0, mk(0,0,0,3,0,0,0), "beq_e_fwd_w");
    step(JR31,   1'b0, mk(0,1,0,0,0,0,0), "jr_fwd_pc8_e");
    step(NOP,    1'b0, mk(0,0,0,2,0,0,0), "jr_e_fwd_pc8_m");
    step(ADDU10, 1'b0, mk(0,4,0,0,0,0,0), "d_fwd_wdata");

    // Register $0 is never a hazard.
    step(ORI0,   1'b0, mk(0,0,0,0,0,0,0), "ori_zero");
    step(ADDU11, 1'b0, mk(0,0,0,0,0,0,0), "read_zero_a");
    step(BEQ00,  1'b0, mk(0,0,0,0,0,0,0), "read_zero_b");

    // Store data: back-to-back uses E then M bypass; with a nop, D then E bypass.
    step(ADDU7,  1'b0, mk(0,0,0,0,0,0,0), "addu7_issue");
    step(SW7,    1'b0, mk(0,0,0,0,0,0,0), "sw_no_stall");
    step(NOP,    1'b0, mk(0,0,0,0,1,0,0), "sw_e_fwd_aluout_m");
    step(NOP,    1'b0, mk(0,0,0,0,0,1,0), "sw_m_fwd_wdata");
    step(ADDU7,  1'b0, mk(0,0,0,0,0,0,0), "addu7_again");
    step(NOP,    1'b0, mk(0,0,0,0,0,0,0), "gap_nop");
    step(SW7,    1'b0, mk(0,0,2,0,0,0,0), "sw_d_fwd_aluout_m");
    step(NOP,    1'b0, mk(0,0,0,0,3,0,0), "sw_e_fwd_w");
    step(NOP,    1'b0, mk(0,0,0,0,0,0,0), "sw_m_no_fwd");

    // lw feeding store data: Tuse 2 equals Tnew 2, so no stall.
    step(LW12,   1'b0, mk(0,0,0,0,0,0,0), "lw12_issue");
    step(SW12,   1'b0, mk(0,0,0,0,0,0,0), "lw_sw_no_stall");
    step(NOP,    1'b0, mk(0,0,0,0,0,0,0), "lw_sw_m_not_ready");
    step(NOP,    1'b0, mk(0,0,0,0,0,1,0), "lw_sw_m_fwd_w");

    // div: ten busy cycles hold mflo in D.
    step(DIV45,  1'b0, mk(0,0,0,0,0,0,0), "div_issue");
    for (int i = 0; i < 10; i++) step(MFLO6, 1'b0, mk(1,0,0,0,0,0,1), "div_busy_stall");
    step(MFLO6,  1'b0, mk(0,0,0,0,0,0,0), "mflo_issue");

    // mult: five busy cycles.
    step(MULT45, 1'b0, mk(0,0,0,0,0,0,0), "mult_issue");
    for (int i = 0; i < 5; i++) step(MFHI2, 1'b0, mk(1,0,0,0,0,0,1), "mult_busy_stall");
    step(MFHI2,  1'b0, mk(0,0,0,0,0,0,0), "mfhi_issue");

    // mult behind a load-use stall must not load the counter early.
    step(LW4,    1'b0, mk(0,0,0,0,0,0,0), "lw4_issue");
    step(MULT45, 1'b0, mk(1,0,0,0,0,0,0), "mult_data_stall");
    step(MULT45, 1'b0, mk(0,0,0,0,0,0,0), "mult_after_stall");
    step(NOP,    1'b0, mk(0,0,0,3,0,0,1), "mult_busy_fwd_w");
    step(MFLO6,  1'b1, mk(1,0,0,0,0,0,1), "reset_asserted_mult");
    step(MFLO6,  1'b0, mk(0,0,0,0,0,0,0), "reset_clears_mult");

    // Reset in the middle of a div.
    step(DIV45,  1'b0, mk(0,0,0,0,0,0,0), "div2_issue");
    step(NOP,    1'b0, mk(0,0,0,0,0,0,1), "div2_busy");
    step(MFLO6,  1'b1, mk(1,0,0,0,0,0,1), "reset_asserted_div");
    step(MFLO6,  1'b0, mk(0,0,0,0,0,0,0), "reset_clears_div");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
